// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-channel PWM LED driver with linear afterglow fade.
// Lit Q_IN bits load full brightness; cleared bits decay one step per fade tick.
//
// Ports:
//   CLK  in  1  system clock, rising edge
//   RST  in  1  synchronous reset, active-high, overrides all other inputs
//   Q_IN in  N  pattern from the upstream generator, sampled every edge
//   EN   in  1  1 = run, 0 = freeze counters/brightness and blank LED
//   LED  out N  registered PWM drive, 1 = on
//   BUSY out 1  high while any channel brightness is non-zero
//
// Build option: define GAMMA_EN for a square-law duty curve, (b*b)>>BW.
// Without it the duty equals the brightness and no multiplier is built.
module led_pwm_fader #(
    parameter int N        = 8,
    parameter int BW       = 4,
    parameter int FADE_DIV = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] Q_IN,
    input  logic         EN,
    output logic [N-1:0] LED,
    output logic         BUSY
);

    localparam logic [BW-1:0] MAX = {BW{1'b1}};
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FADE_DIV - 1);

    logic [BW-1:0] pwm_cnt;
    logic [FW-1:0] fade_cnt;
    logic [BW-1:0] bright [N];
    logic [BW-1:0] duty   [N];
    logic [N-1:0]  led_nxt;
    logic          pwm_wrap;
    logic          fade_tick;
    logic          busy_c;

    assign pwm_wrap  = (pwm_cnt == MAX);
    assign fade_tick = EN & pwm_wrap & (fade_cnt == FLAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else if (EN) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap) begin
                fade_cnt <= (fade_cnt == FLAST) ? '0 : fade_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_duty
`ifdef GAMMA_EN
        logic [2*BW-1:0] sq;
        assign sq = {{BW{1'b0}}, bright[i]} * {{BW{1'b0}}, bright[i]};
        assign duty[i] = sq[2*BW-1:BW];
`else
        assign duty[i] = bright[i];
`endif
    end

    // A load wins over a coincident fade step; zero saturates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) bright[i] <= '0;
        end else if (EN) begin
            for (int i = 0; i < N; i++) begin
                if (Q_IN[i]) begin
                    bright[i] <= MAX;
                end else if (fade_tick && (bright[i] != '0)) begin
                    bright[i] <= bright[i] - 1'b1;
                end
            end
        end
    end

    // Full brightness is forced solid on; the compare alone would drop
    // the pwm_cnt==MAX slot.
    always_comb begin
        led_nxt = '0;
        busy_c  = 1'b0;
        for (int i = 0; i < N; i++) begin
            led_nxt[i] = EN & ((bright[i] == MAX) | (pwm_cnt < duty[i]));
            busy_c     = busy_c | (bright[i] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            LED <= '0;
        end else begin
            LED <= led_nxt;
        end
    end

    assign BUSY = busy_c;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench for led_pwm_fader (N=8, BW=4, FADE_DIV=2).
// Stimulus queues expected LED/BUSY values; a negedge monitor compares them.
module tb_led_pwm_fader;

    logic       CLK;
    logic       RST;
    logic [7:0] Q_IN;
    logic       EN;
    logic [7:0] LED;
    logic       BUSY;

    led_pwm_fader #(.N(8), .BW(4), .FADE_DIV(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .Q_IN(Q_IN),
        .EN  (EN),
        .LED (LED),
        .BUSY(BUSY)
    );

`ifdef GAMMA_EN
    localparam int D14 = 12;
    localparam int D12 = 9;
    localparam int D8  = 4;
    localparam logic [7:0] B1ON = 8'h00;
`else
    localparam int D14 = 14;
    localparam int D12 = 12;
    localparam int D8  = 8;
    localparam logic [7:0] B1ON = 8'h01;
`endif

    typedef struct {
        int         kind;
        string      name;
        logic [7:0] led;
        logic       busy;
        int         ch;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    int   ecnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Enabled-edge count since reset: after edge e, pwm_cnt = e mod 16
    // and fade ticks land on e = 32, 64, ...
    always @(posedge CLK) begin
        if (RST) ecnt = 0;
        else if (EN) ecnt = ecnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                automatic exp_t e = sb.pop_front();
                if (e.kind == 0) begin
                    nchk++;
                    if (LED !== e.led || BUSY !== e.busy) begin
                        nerr++;
                        $display("FAIL %s: LED=%h BUSY=%b, want LED=%h BUSY=%b",
                                 e.name, LED, BUSY, e.led, e.busy);
                    end
                end else begin
                    automatic int c = int'(LED[e.ch]);
                    for (int k = 1; k < 16; k++) begin
                        @(negedge CLK);
                        c += int'(LED[e.ch]);
                    end
                    nchk++;
                    if (c != e.cnt) begin
                        nerr++;
                        $display("FAIL %s: LED[%0d] high %0d of 16, want %0d",
                                 e.name, e.ch, c, e.cnt);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] l, input logic b);
        exp_t e;
        e.kind = 0; e.name = nm; e.led = l; e.busy = b; e.ch = 0; e.cnt = 0;
        sb.push_back(e);
    endtask

    task automatic chk_cnt(input string nm, input int ch, input int c);
        exp_t e;
        e.kind = 1; e.name = nm; e.led = '0; e.busy = 1'b0; e.ch = ch; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic wait_e(input int n);
        int g = 0;
        while (ecnt < n) begin
            tick();
            g++;
            if (g > 5000) begin
                $display("FAIL wait_e: edge %0d not reached", n);
                $fatal(1, "stall");
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; Q_IN = 8'h00; EN = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; Q_IN = 8'h00; EN = 1'b0;

        // reset priority and load latency
        Q_IN = 8'hFF; EN = 1'b1;
        repeat (3) tick();
        chk("rst_state", 8'h00, 1'b0);
        RST = 1'b0;
        tick(); chk("load_lat1", 8'h00, 1'b1);
        tick(); chk("load_lat2", 8'hFF, 1'b1);
        tick();

        // single channel held lit
        do_reset();
        Q_IN = 8'h01;
        tick(); chk("q01_lat1", 8'h00, 1'b1);
        for (int e = 2; e <= 40; e++) begin
            tick(); chk("q01_hold", 8'h01, 1'b1);
        end

        // single channel fade
        do_reset();
        Q_IN = 8'h01;
        wait_e(32); Q_IN = 8'h00;
        wait_e(63);  chk("fade_b15", 8'h01, 1'b1);
        wait_e(65);  chk_cnt("duty14", 0, D14);
        wait_e(257); chk_cnt("duty8", 0, D8);
        wait_e(497); chk("fade_b1_on", B1ON, 1'b1);
        wait_e(511); chk("fade_b1_off", 8'h00, 1'b1);
        wait_e(512); chk("fade_zero", 8'h00, 1'b0);
        wait_e(600); chk("sat_zero", 8'h00, 1'b0);

        // stair then common fade
        do_reset();
        for (int j = 0; j < 8; j++) begin
            logic [7:0] s;
            logic [7:0] p;
            s = 8'((1 << (j + 1)) - 1);
            p = 8'((1 << j) - 1);
            wait_e(64 * j);
            Q_IN = s;
            tick(); chk("stair_old", p, 1'b1);
            tick(); chk("stair_new", s, 1'b1);
        end
        wait_e(512); Q_IN = 8'h00;
        wait_e(737); chk("all_b8_on", 8'hFF, 1'b1);
        wait_e(745); chk("all_b8_off", 8'h00, 1'b1);
        wait_e(753); chk_cnt("all_duty8", 7, D8);
        wait_e(991); chk("all_b1", 8'h00, 1'b1);
        wait_e(992); chk("all_zero", 8'h00, 1'b0);

        // pause mid-fade
        do_reset();
        Q_IN = 8'h01;
        wait_e(32); Q_IN = 8'h00;
        wait_e(100); EN = 1'b0;
        tick(); chk("pause_blank", 8'h00, 1'b1);
        repeat (98) tick();
        chk("pause_hold", 8'h00, 1'b1);
        tick(); EN = 1'b1;
        tick(); chk("resume", 8'h01, 1'b1);
        wait_e(129); chk_cnt("resume_duty12", 0, D12);

        // reset mid-fade while disabled
        wait_e(150);
        RST = 1'b1; EN = 1'b0;
        tick(); chk("rst_mid", 8'h00, 1'b0);
        RST = 1'b0; EN = 1'b1; Q_IN = 8'h00;
        tick(); chk("rst_after", 8'h00, 1'b0);
        Q_IN = 8'h01;
        tick(); chk("rst_reload", 8'h00, 1'b1);

        repeat (20) tick();
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL sb_drain: %0d left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
